padded_ifm_reader: RTL and testbench

PADDED_IFM_READER -- requirements
Module: padded_ifm_reader

---
 rtl/padded_ifm_reader_pkg.sv | 15 +
 rtl/padded_ifm_reader_skid_fifo2.sv | 50 +++++
 rtl/padded_ifm_reader.sv | 186 ++++++++++++++++++
 tb/tb_padded_ifm_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/padded_ifm_reader_pkg.sv
// rtl/padded_ifm_reader_pkg.sv - shared state encoding and constants for the padded IFM reader
package padded_ifm_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned ADDR_STEP  = 4;
    localparam int          PE_DEFAULT = 16;

endpackage

// File: rtl/padded_ifm_reader_skid_fifo2.sv
// rtl/padded_ifm_reader_skid_fifo2.sv - two-entry skid FIFO holding returned words plus their tags
module skid_fifo2 #(
    parameter int W = 130
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/padded_ifm_reader.sv
// rtl/padded_ifm_reader.sv - walks K-row windows of a padded IFM buffer and streams the words out
module padded_ifm_reader
    import padded_ifm_reader_pkg::*;
#(
    parameter int PE = PE_DEFAULT,
    parameter int K  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      IFM_C,
    input  logic [7:0]      IFM_W,
    input  logic            padding,
    input  logic            row_avail,
    output logic            rd_en,
    output logic [31:0]     rd_addr,
    input  logic [PE*8-1:0] rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PE*8-1:0] out_data,
    output logic            out_last_row,
    output logic            out_last_win,
    output logic            busy,
    output logic            done
);

    state_t      r_state;
    logic [7:0]  r_c;
    logic [7:0]  r_wd;
    logic        r_pad;
    logic [31:0] r_wpr;
    logic [31:0] r_nwin;
    logic [31:0] r_w;
    logic [31:0] r_k;
    logic [31:0] r_j;
    logic [31:0] r_idx;
    logic [31:0] r_win_base;
    logic [8:0]  r_rows;
    logic        r_pend;
    logic [1:0]  r_pend_tag;
    logic        r_busy;
    logic        r_done;

    logic [31:0]      w_pw;
    logic [31:0]      w_wpr;
    logic [31:0]      w_nwin;
    logic [31:0]      w_row;
    logic             w_row_ok;
    logic             w_pop;
    logic [1:0]       w_occ;
    logic             w_room;
    logic             w_issue;
    logic             w_j_last;
    logic             w_k_last;
    logic             w_w_last;
    logic [PE*8+1:0]  w_fifo_q;

    assign w_pw   = {24'd0, r_wd} + (r_pad ? 32'd2 : 32'd0);
    assign w_wpr  = (w_pw * {24'd0, r_c}) / 32'(PE);
    assign w_nwin = (w_pw >= 32'(K)) ? (w_pw - 32'(K) + 32'd1) : 32'd0;

    assign w_pop    = out_valid && out_ready;
    // A word leaving this cycle frees its slot, which keeps the stream at one word per cycle.
    assign w_room   = ({1'b0, w_occ} + {2'b0, r_pend} - {2'b0, w_pop}) < 3'd2;
    assign w_row    = r_w + r_k;
    assign w_row_ok = {23'd0, r_rows} > w_row;
    assign w_issue  = (r_state == S_READ) && w_room && w_row_ok;

    assign w_j_last = (r_j == r_wpr - 32'd1);
    assign w_k_last = (r_k == 32'(K - 1));
    assign w_w_last = (r_w == r_nwin - 32'd1);

    assign rd_en   = w_issue;
    assign rd_addr = r_idx * ADDR_STEP;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows <= 9'd0;
        end else if (start && (r_state == S_IDLE)) begin
            r_rows <= row_avail ? 9'd1 : 9'd0;
        end else if (row_avail && (r_rows != 9'h1FF)) begin
            r_rows <= r_rows + 9'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_c        <= 8'd0;
            r_wd       <= 8'd0;
            r_pad      <= 1'b0;
            r_wpr      <= 32'd0;
            r_nwin     <= 32'd0;
            r_w        <= 32'd0;
            r_k        <= 32'd0;
            r_j        <= 32'd0;
            r_idx      <= 32'd0;
            r_win_base <= 32'd0;
            r_pend     <= 1'b0;
            r_pend_tag <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_pend     <= w_issue;
            r_pend_tag <= {w_j_last && w_k_last, w_j_last};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_c        <= IFM_C;
                        r_wd       <= IFM_W;
                        r_pad      <= padding;
                        r_w        <= 32'd0;
                        r_k        <= 32'd0;
                        r_j        <= 32'd0;
                        r_idx      <= 32'd0;
                        r_win_base <= 32'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wpr   <= w_wpr;
                    r_nwin  <= w_nwin;
                    r_state <= ((w_wpr == 32'd0) || (w_nwin == 32'd0)) ? S_DRAIN : S_READ;
                end
                S_READ: begin
                    if (w_issue) begin
                        // Rows of a window are contiguous; only the window step jumps back.
                        if (w_j_last) begin
                            r_j <= 32'd0;
                            if (w_k_last) begin
                                r_k        <= 32'd0;
                                r_w        <= r_w + 32'd1;
                                r_idx      <= r_win_base + r_wpr;
                                r_win_base <= r_win_base + r_wpr;
                                if (w_w_last) begin
                                    r_state <= S_DRAIN;
                                end
                            end else begin
                                r_k   <= r_k + 32'd1;
                                r_idx <= r_idx + 32'd1;
                            end
                        end else begin
                            r_j   <= r_j + 32'd1;
                            r_idx <= r_idx + 32'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((w_occ == 2'd0) && !r_pend) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    skid_fifo2 #(
        .W(PE*8 + 2)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_data  ({r_pend_tag, rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_valid (out_valid),
        .o_count (w_occ)
    );

    assign out_data     = w_fifo_q[PE*8-1:0];
    assign out_last_row = w_fifo_q[PE*8];
    assign out_last_win = w_fifo_q[PE*8+1];

endmodule

// File: tb/tb_padded_ifm_reader.sv
// tb/tb_padded_ifm_reader.sv - scoreboard bench for padded_ifm_reader
module tb_padded_ifm_reader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   ifm_c = 8'd0;
    logic [7:0]   ifm_w = 8'd0;
    logic         padding = 1'b0;
    logic         row_avail = 1'b0;
    logic         out_ready = 1'b0;
    logic         rd_en;
    logic [31:0]  rd_addr;
    logic [127:0] rd_data;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_last_row;
    logic         out_last_win;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    padded_ifm_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .IFM_C        (ifm_c),
        .IFM_W        (ifm_w),
        .padding      (padding),
        .row_avail    (row_avail),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last_row (out_last_row),
        .out_last_win (out_last_win),
        .busy         (busy),
        .done         (done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rows_released = 0;
    int cur_wpr = 1;
    int done_cnt = 0;
    int lastwin_cnt = 0;
    int xfer_cnt = 0;
    int first_valid_cyc = -1;
    int first_xfer_cyc = -1;
    int last_xfer_cyc = -1;
    int t_start = 0;
    int rdy_mode = 0;

    logic [31:0]  exp_addr [$];
    logic [129:0] exp_word [$];

    logic        m_pend = 1'b0;
    logic [31:0] m_addr = 32'd0;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'hDEAD_0000, ~a, a + 32'h1357_9BDF, {a[15:0], a[31:16]}};
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_pend <= rd_en;
        m_addr <= rd_addr;
    end

    assign rd_data = m_pend ? pat(m_addr) : 128'd0;

    task automatic chk(input bit ok, input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        bit           prev_stall;
        logic [129:0] prev_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (rd_en) begin
                    int row;
                    row = int'(rd_addr) / 4 / cur_wpr;
                    if (exp_addr.size() == 0) begin
                        chk(1'b0, "rd_unexpected", rd_addr, 0);
                    end else begin
                        logic [31:0] a;
                        a = exp_addr.pop_front();
                        chk(rd_addr == a, "rd_addr", rd_addr, a);
                    end
                    chk(row < rows_released, "row_gate", row, rows_released);
                end
                if (prev_stall) begin
                    chk(out_valid && ({out_last_win, out_last_row, out_data} == prev_word), "hold",
                        {out_last_win, out_last_row, out_data}, prev_word);
                end
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (exp_word.size() == 0) begin
                        chk(1'b0, "out_unexpected", {out_last_win, out_last_row, out_data}, 0);
                    end else begin
                        logic [129:0] e;
                        e = exp_word.pop_front();
                        chk({out_last_win, out_last_row, out_data} == e, "out_word",
                            {out_last_win, out_last_row, out_data}, e);
                    end
                    xfer_cnt++;
                    if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    if (out_last_win) lastwin_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last_win, out_last_row, out_data};
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ~out_ready;
            else                    out_ready = 1'b0;
        end
    end

    task automatic load_frame(input int c, input int wd, input int p);
        int pw, wpr, nwin;
        pw   = wd + 2 * p;
        wpr  = pw * c / 16;
        nwin = pw - 3 + 1;
        cur_wpr = wpr;
        ifm_c = 8'(c);
        ifm_w = 8'(wd);
        padding = p[0];
        done_cnt = 0; lastwin_cnt = 0; xfer_cnt = 0;
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        rows_released = 0;
        for (int w = 0; w < nwin; w++)
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < wpr; j++) begin
                    logic [31:0] a;
                    a = 32'(((w + k) * wpr + j) * 4);
                    exp_addr.push_back(a);
                    exp_word.push_back({(j == wpr - 1) && (k == 2), j == wpr - 1, pat(a)});
                end
    endtask

    task automatic pulse_start(input bit with_row);
        @(posedge clk);
        #1;
        start = 1'b1;
        row_avail = with_row;
        @(posedge clk);
        #1;
        t_start = cyc;
        start = 1'b0;
        row_avail = 1'b0;
        if (with_row) rows_released++;
    endtask

    task automatic release_rows(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            row_avail = 1'b1;
            @(posedge clk);
            #1;
            row_avail = 1'b0;
            rows_released++;
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
        end
    endtask

    task automatic wait_done(input string name, input int nwords, input int nwin);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(done_cnt == 1, {name, "_done_once"}, done_cnt, 1);
        chk(xfer_cnt == nwords, {name, "_words"}, xfer_cnt, nwords);
        chk(lastwin_cnt == nwin, {name, "_last_win"}, lastwin_cnt, nwin);
        chk(exp_addr.size() == 0, {name, "_reads_left"}, exp_addr.size(), 0);
        chk(!busy, {name, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(rd_en == 1'b0, "rst_rd_en", rd_en, 0);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", {busy, done}, 0);
        chk(rd_addr == 32'd0, "rst_rd_addr", rd_addr, 0);
        chk(out_data == 128'd0 && !out_last_row && !out_last_win, "rst_out",
            {out_last_win, out_last_row, out_data}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        rdy_mode = 0;
        load_frame(16, 4, 1);
        pulse_start(1'b1);
        chk(busy == 1'b1, "busy_after_start", busy, 1);
        release_rows(5, 0);
        wait_done("full", 72, 4);
        chk(first_valid_cyc - t_start == 3, "first_latency", first_valid_cyc - t_start, 3);
        chk(last_xfer_cyc - first_xfer_cyc == 71, "throughput", last_xfer_cyc - first_xfer_cyc, 71);

        rdy_mode = 1;
        load_frame(16, 4, 1);
        pulse_start(1'b1);
        release_rows(5, 0);
        wait_done("toggle", 72, 4);

        rdy_mode = 0;
        load_frame(16, 4, 1);
        pulse_start(1'b0);
        fork
            release_rows(6, 19);
            wait_done("gated", 72, 4);
        join

        load_frame(32, 5, 0);
        pulse_start(1'b1);
        fork
            release_rows(4, 0);
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                start = 1'b1;
                ifm_c = 8'd16;
                ifm_w = 8'd4;
                padding = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done("c32", 90, 3);

        load_frame(16, 4, 1);
        pulse_start(1'b1);
        n = 0;
        while (!rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(rd_en == 1'b1, "reset_setup_read", rd_en, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_addr.delete();
        exp_word.delete();
        @(negedge clk);
        chk(!busy && !out_valid && !rd_en, "mid_reset_idle", {busy, out_valid, rd_en}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk(!out_valid, "late_data_dropped", out_valid, 0);
        end
        chk(!busy, "after_reset_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
